bus_demux: RTL

BUS_DEMUX -- requirements
Module: bus_demux

---
 rtl/bus_demux.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bus_demux.sv
// Address-decoding demultiplexer: one upstream request port fanned out to
// NPORTS downstream ports, with decode-miss errors and an optional response timeout.
module bus_demux #(
  parameter int                      NPORTS     = 2,
  parameter int                      ADDRW      = 32,
  parameter int                      DATAW      = 32,
  parameter int                      MASKW      = DATAW / 8,
  parameter logic [NPORTS*ADDRW-1:0] BASE_ADDRS = {32'h1000_0000, 32'h0000_0000},
  parameter logic [NPORTS*ADDRW-1:0] ADDR_MASKS = {2{32'hF000_0000}},
  parameter int                      TIMEOUT    = 0,
  parameter logic [DATAW-1:0]        ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDRW-1:0]        slave_addr_i,
  output logic [DATAW-1:0]        slave_rdata_o,
  input  logic [DATAW-1:0]        slave_wdata_i,
  input  logic [MASKW-1:0]        slave_mask_i,
  input  logic                    slave_we_i,
  input  logic                    slave_valid_i,
  output logic                    slave_resp_o,
  output logic                    slave_err_o,
  output logic [NPORTS*ADDRW-1:0] master_addr_o,
  output logic [NPORTS*DATAW-1:0] master_wdata_o,
  output logic [NPORTS*MASKW-1:0] master_mask_o,
  output logic [NPORTS-1:0]       master_we_o,
  input  logic [NPORTS*DATAW-1:0] master_rdata_i,
  output logic [NPORTS-1:0]       master_valid_o,
  input  logic [NPORTS-1:0]       master_resp_i,
  output logic                    busy_o,
  output logic [1:0]              dbg_state_o
);

  // Handshake: a requester raises valid and holds it with stable fields until
  // it sees a one-cycle resp pulse; resp (with err) completes the transfer.
  // The same rule applies on each downstream port.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam int SELW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] w_sel_nxt;
  logic            w_hit;
  logic [SELW-1:0] w_hit_idx;
  logic            w_sel_resp;
  logic            w_timeout;

  // Walk from the top index down so the lowest matching port is the final winner.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if ((slave_addr_i & ADDR_MASKS[i*ADDRW +: ADDRW]) ==
          (BASE_ADDRS[i*ADDRW +: ADDRW] & ADDR_MASKS[i*ADDRW +: ADDRW])) begin
        w_hit     = 1'b1;
        w_hit_idx = SELW'(i);
      end
    end
  end

  assign w_sel_resp = master_resp_i[r_sel];

  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int CNTW = $clog2(TIMEOUT + 1);
      logic [CNTW-1:0] r_cnt;

      // Counts BUSY cycles already spent, so it reads k-1 in the k-th BUSY cycle.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_cnt <= '0;
        end else if (r_state == S_BUSY && w_state_nxt == S_BUSY) begin
          if (r_cnt != CNTW'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt <= '0;
        end
      end

      assign w_timeout = (r_state == S_BUSY) && (r_cnt == CNTW'(TIMEOUT - 1));
    end else begin : g_no_tmo
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    master_valid_o = '0;
    slave_resp_o   = 1'b0;
    slave_err_o    = 1'b0;
    slave_rdata_o  = '0;
    case (r_state)
      S_IDLE: begin
        if (slave_valid_i) begin
          if (w_hit) begin
            w_sel_nxt   = w_hit_idx;
            w_state_nxt = S_BUSY;
          end else begin
            w_state_nxt = S_ERR;
          end
        end
      end
      S_BUSY: begin
        // A real response takes priority over a timeout expiring in the same cycle.
        if (w_sel_resp) begin
          master_valid_o[r_sel] = slave_valid_i;
          slave_resp_o          = 1'b1;
          slave_rdata_o         = master_rdata_i[int'(r_sel)*DATAW +: DATAW];
          w_state_nxt           = S_IDLE;
        end else if (w_timeout) begin
          slave_resp_o  = 1'b1;
          slave_err_o   = 1'b1;
          slave_rdata_o = ERR_DATA;
          w_state_nxt   = S_IDLE;
        end else begin
          master_valid_o[r_sel] = slave_valid_i;
        end
      end
      S_ERR: begin
        slave_resp_o  = 1'b1;
        slave_err_o   = 1'b1;
        slave_rdata_o = ERR_DATA;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign master_addr_o  = {NPORTS{slave_addr_i}};
  assign master_wdata_o = {NPORTS{slave_wdata_i}};
  assign master_mask_o  = {NPORTS{slave_mask_i}};
  assign master_we_o    = {NPORTS{slave_we_i}};
  assign busy_o         = (r_state != S_IDLE);
  assign dbg_state_o    = r_state;

endmodule
